// File: rtl/beer_pkg.sv
// Shared constants for the beer tap scheduler: state encodings, glass level codes, pour result codes.
package beer_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] GRANT = 3'd1;
  localparam logic [2:0] FOAM  = 3'd2;
  localparam logic [2:0] POUR  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [1:0] LVL_NONE = 2'd0;
  localparam logic [1:0] LVL_PART = 2'd1;
  localparam logic [1:0] LVL_FULL = 2'd2;
  localparam logic [1:0] LVL_OVER = 2'd3;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_ABORT   = 2'd1;
  localparam logic [1:0] ST_OVER    = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/beer_tap_scheduler_if.sv
// Station/tap side signal bundle of the beer tap scheduler.
interface beer_tap_scheduler_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0] req;
  logic [1:0]       beer_level;
  logic [N_REQ-1:0] grant;
  logic             draft;
  logic             valve;
  logic             busy;
  logic             done;
  logic [1:0]       status;
  logic [2:0]       state_display;

  modport master (
    output req, beer_level,
    input  grant, draft, valve, busy, done, status, state_display
  );

  modport slave (
    input  req, beer_level,
    output grant, draft, valve, busy, done, status, state_display
  );
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping at N_REQ.
module rr_picker #(
  parameter  int N_REQ = 4,
  localparam int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] winner,
  output logic             valid
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(N_REQ)) begin
        sum = sum - (PTR_W+1)'(N_REQ);
      end
      idx = sum[PTR_W-1:0];
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/beer_tap_scheduler.sv
// Shares one beer tap between N_REQ stations and sequences each pour.
// Optional POUR watchdog enabled by defining POUR_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no pour; arbitrate among active requests
// GRANT | tap owned, waiting for a glass
// FOAM  | draft on, valve closed, for FOAM_CYCLES cycles
// POUR  | draft and valve on until full, overflow, drop or watchdog
// DONE  | one-cycle completion pulse, advance round-robin pointer
module beer_tap_scheduler
  import beer_pkg::*;
#(
  parameter int N_REQ           = 4,
  parameter int FOAM_CYCLES     = 8,
  parameter int POUR_MAX_CYCLES = 255
) (
  input  logic          clk,
  input  logic          reset,
  beer_tap_scheduler_if.slave bus
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(max_int(FOAM_CYCLES, POUR_MAX_CYCLES) + 1);
  localparam logic [CNT_W-1:0] FOAM_LAST = CNT_W'(FOAM_CYCLES - 1);
`ifdef POUR_TIMEOUT_EN
  localparam logic [CNT_W-1:0] POUR_LAST = CNT_W'(POUR_MAX_CYCLES - 1);
`endif

  logic [2:0]       state_q,  state_d;
  logic [PTR_W-1:0] winner_q, winner_d;
  logic [PTR_W-1:0] ptr_q,    ptr_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [N_REQ-1:0] grant_q,  grant_d;
  logic             draft_q,  draft_d;
  logic             valve_q,  valve_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [1:0]       status_q, status_d;

  logic [PTR_W-1:0] pick_idx;
  logic             pick_vld;
  logic             owner_req;
  logic [CNT_W-1:0] cnt_inc;
  logic [1:0]       fin_status;

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req    (bus.req),
    .ptr    (ptr_q),
    .winner (pick_idx),
    .valid  (pick_vld)
  );

  assign owner_req = bus.req[winner_q];
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    winner_d   = winner_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    fin_status = ST_OK;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          winner_d = pick_idx;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          state_d    = DONE;
          fin_status = ST_ABORT;
        end else if (bus.beer_level == LVL_OVER) begin
          state_d    = DONE;
          fin_status = ST_OVER;
        end else if (bus.beer_level != LVL_NONE) begin
          state_d = FOAM;
          cnt_d   = '0;
        end
      end
      FOAM: begin
        if (bus.beer_level == LVL_OVER) begin
          state_d    = DONE;
          fin_status = ST_OVER;
        end else if (!owner_req) begin
          state_d    = DONE;
          fin_status = ST_ABORT;
        end else if (cnt_q == FOAM_LAST) begin
          state_d = POUR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      POUR: begin
        // Full beats a same-cycle request drop: the glass is already poured.
        if (bus.beer_level == LVL_OVER) begin
          state_d    = DONE;
          fin_status = ST_OVER;
        end else if (bus.beer_level == LVL_FULL) begin
          state_d    = DONE;
          fin_status = ST_OK;
        end else if (!owner_req) begin
          state_d    = DONE;
          fin_status = ST_ABORT;
`ifdef POUR_TIMEOUT_EN
        end else if (cnt_q == POUR_LAST) begin
          state_d    = DONE;
          fin_status = ST_TIMEOUT;
        end else begin
          cnt_d = cnt_inc;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
        ptr_d   = (winner_q == PTR_W'(N_REQ - 1)) ? '0 : winner_q + PTR_W'(1);
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from the next state so they line up with state_display.
    draft_d  = (state_d == FOAM) || (state_d == POUR);
    valve_d  = (state_d == POUR);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
    status_d = (state_d == DONE) ? fin_status : ST_OK;
    grant_d  = ((state_d == GRANT) || (state_d == FOAM) || (state_d == POUR))
               ? (N_REQ'(1) << winner_d) : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      winner_q <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      grant_q  <= '0;
      draft_q  <= 1'b0;
      valve_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      status_q <= ST_OK;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      draft_q  <= draft_d;
      valve_q  <= valve_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      status_q <= status_d;
    end
  end

  assign bus.grant         = grant_q;
  assign bus.draft         = draft_q;
  assign bus.valve         = valve_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.status        = status_q;
  assign bus.state_display = state_q;

endmodule

// File: tb/tb_beer_tap_scheduler.sv
// Self-checking bench for beer_tap_scheduler: vector table, directed corner cases, random vs. reference model.
module tb_beer_tap_scheduler;

  localparam int N    = 4;
  localparam int FOAM = 8;
  localparam int PMAX = 16;
`ifdef POUR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  beer_tap_scheduler_if #(.N_REQ(N)) bus ();

  beer_tap_scheduler #(
    .N_REQ           (N),
    .FOAM_CYCLES     (FOAM),
    .POUR_MAX_CYCLES (PMAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase 0 idle, 1 granted, 2 foam, 3 pour, 4 done.
  int m_phase, m_owner, m_ptr, m_elapsed, m_status;

  typedef struct {
    logic [3:0] req;
    logic [1:0] lvl;
    logic [3:0] grant;
    logic       draft;
    logic       valve;
    logic       done;
    logic [1:0] status;
    logic [2:0] st;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [3:0] r, logic [1:0] l, logic [3:0] g, logic d, logic v,
                              logic dn, logic [1:0] s, logic [2:0] st);
    vec_t x;
    x.req = r; x.lvl = l; x.grant = g; x.draft = d; x.valve = v;
    x.done = dn; x.status = s; x.st = st;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_ptr = 0; m_elapsed = 0; m_status = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [1:0] l);
    int  c;
    bit  found;
    logic held;
    held = r[m_owner[1:0]];
    case (m_phase)
      0: if (r != 0) begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (!found && r[c[1:0]]) begin
            m_owner = c;
            found = 1;
          end
        end
        m_phase = 1;
      end
      1: begin
        if (!held)        begin m_phase = 4; m_status = 1; end
        else if (l == 3)  begin m_phase = 4; m_status = 2; end
        else if (l != 0)  begin m_phase = 2; m_elapsed = 0; end
      end
      2: begin
        m_elapsed++;
        if (l == 3)                 begin m_phase = 4; m_status = 2; end
        else if (!held)             begin m_phase = 4; m_status = 1; end
        else if (m_elapsed == FOAM) begin m_phase = 3; m_elapsed = 0; end
      end
      3: begin
        m_elapsed++;
        if (l == 3)                          begin m_phase = 4; m_status = 2; end
        else if (l == 2)                     begin m_phase = 4; m_status = 0; end
        else if (!held)                      begin m_phase = 4; m_status = 1; end
        else if (TO_EN && m_elapsed == PMAX) begin m_phase = 4; m_status = 3; end
      end
      default: begin
        m_phase = 0;
        m_ptr = (m_owner + 1) % N;
      end
    endcase
  endtask

  function automatic logic [12:0] dut_vec();
    return {bus.grant, bus.draft, bus.valve, bus.busy, bus.done, bus.status, bus.state_display};
  endfunction

  function automatic logic [12:0] model_vec();
    logic [3:0] g;
    logic [1:0] s;
    g = (m_phase >= 1 && m_phase <= 3) ? 4'(1 << m_owner) : 4'd0;
    s = (m_phase == 4) ? 2'(m_status) : 2'd0;
    return {g, (m_phase == 2 || m_phase == 3), (m_phase == 3), (m_phase != 0),
            (m_phase == 4), s, 3'(m_phase)};
  endfunction

  task automatic step(input logic [3:0] r, input logic [1:0] l);
    bus.req = r;
    bus.beer_level = l;
    @(posedge clk);
    model_step(r, l);
    @(negedge clk);
    check("cycle_vs_model", 32'(dut_vec()), 32'(model_vec()));
  endtask

  task automatic pour_once(input string name, input logic [3:0] mask, input logic [3:0] exp_g);
    step(mask, 2'd0);
    check({name, "_grant"}, 32'(bus.grant), 32'(exp_g));
    for (int i = 0; i < 40 && !bus.done; i++) step(mask, 2'd2);
    check({name, "_done"}, 32'(bus.done), 32'd1);
    check({name, "_status"}, 32'(bus.status), 32'd0);
    step(mask, 2'd0);
  endtask

  task automatic to_pour(input logic [3:0] r);
    step(r, 2'd0);
    step(r, 2'd1);
    repeat (FOAM) step(r, 2'd1);
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int wd;
    bit seen_done;
    logic [3:0] rr;
    logic [1:0] ll;

    // req, lvl -> grant, draft, valve, done, status, state
    tbl.push_back(mk(4'h1, 2'd0, 4'h1, 0, 0, 0, 2'd0, 3'd1));
    tbl.push_back(mk(4'h1, 2'd0, 4'h1, 0, 0, 0, 2'd0, 3'd1));
    tbl.push_back(mk(4'h1, 2'd1, 4'h1, 1, 0, 0, 2'd0, 3'd2));
    for (int i = 0; i < FOAM - 1; i++) tbl.push_back(mk(4'h1, 2'd1, 4'h1, 1, 0, 0, 2'd0, 3'd2));
    tbl.push_back(mk(4'h1, 2'd1, 4'h1, 1, 1, 0, 2'd0, 3'd3));
    tbl.push_back(mk(4'h1, 2'd1, 4'h1, 1, 1, 0, 2'd0, 3'd3));
    tbl.push_back(mk(4'h1, 2'd2, 4'h0, 0, 0, 1, 2'd0, 3'd4));
    tbl.push_back(mk(4'h0, 2'd0, 4'h0, 0, 0, 0, 2'd0, 3'd0));
    tbl.push_back(mk(4'h1, 2'd0, 4'h1, 0, 0, 0, 2'd0, 3'd1));
    tbl.push_back(mk(4'h1, 2'd1, 4'h1, 1, 0, 0, 2'd0, 3'd2));
    tbl.push_back(mk(4'h1, 2'd3, 4'h0, 0, 0, 1, 2'd2, 3'd4));
    tbl.push_back(mk(4'h0, 2'd0, 4'h0, 0, 0, 0, 2'd0, 3'd0));
    tbl.push_back(mk(4'h4, 2'd0, 4'h4, 0, 0, 0, 2'd0, 3'd1));
    tbl.push_back(mk(4'h0, 2'd0, 4'h0, 0, 0, 1, 2'd1, 3'd4));
    tbl.push_back(mk(4'h0, 2'd0, 4'h0, 0, 0, 0, 2'd0, 3'd0));

    reset = 1'b0;
    bus.req = '0;
    bus.beer_level = 2'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'(dut_vec()), 32'd0);
    reset = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].req, tbl[i].lvl);
      check($sformatf("tbl%0d", i),
            32'({bus.grant, bus.draft, bus.valve, bus.done, bus.status, bus.state_display}),
            32'({tbl[i].grant, tbl[i].draft, tbl[i].valve, tbl[i].done, tbl[i].status, tbl[i].st}));
    end

    // Fairness from a fresh pointer.
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    pour_once("fair_a", 4'b0101, 4'b0001);
    pour_once("fair_b", 4'b0101, 4'b0100);
    pour_once("fair_c", 4'b0101, 4'b0001);
    pour_once("all_a", 4'b1111, 4'b0010);
    pour_once("all_b", 4'b1111, 4'b0100);
    pour_once("all_c", 4'b1111, 4'b1000);
    pour_once("all_d", 4'b1111, 4'b0001);

    // Drop coincident with full: full wins.
    to_pour(4'b0001);
    check("sim_in_pour", 32'(bus.state_display), 32'd3);
    step(4'b0000, 2'd2);
    check("sim_done", 32'(bus.done), 32'd1);
    check("sim_status", 32'(bus.status), 32'd0);
    step(4'b0000, 2'd0);

    // Drop alone in POUR.
    to_pour(4'b0010);
    check("drop_grant", 32'(bus.grant), 32'b0010);
    step(4'b0000, 2'd1);
    check("drop_status", 32'(bus.status), 32'd1);
    step(4'b0000, 2'd0);

    // Asynchronous reset in the middle of POUR.
    to_pour(4'b0100);
    check("rst_pre_valve", 32'(bus.valve), 32'd1);
    #2 reset = 1'b0;
    #1 check("rst_async_outputs", 32'(dut_vec()), 32'd0);
    model_reset();
    bus.req = '0;
    seen_done = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.done) seen_done = 1;
    end
    check("rst_no_done", 32'(seen_done), 32'd0);
    reset = 1'b1;
    step(4'b1111, 2'd0);
    check("rst_ptr_zero", 32'(bus.grant), 32'b0001);

    // Watchdog behaviour with a glass stuck at partial.
    step(4'b0001, 2'd1);
    repeat (FOAM) step(4'b0001, 2'd1);
    check("wd_in_pour", 32'(bus.state_display), 32'd3);
`ifdef POUR_TIMEOUT_EN
    wd = 0;
    while (!bus.done && wd < 100) begin
      step(4'b0001, 2'd1);
      wd++;
    end
    check("wd_cycles", 32'(wd), 32'(PMAX));
    check("wd_status", 32'(bus.status), 32'd3);
`else
    wd = 0;
    seen_done = 0;
    repeat (1000) begin
      step(4'b0001, 2'd1);
      if (bus.done) seen_done = 1;
      wd++;
    end
    check("nowd_no_done", 32'(seen_done), 32'd0);
    check("nowd_still_pour", 32'(bus.state_display), 32'd3);
    step(4'b0000, 2'd1);
    check("nowd_abort", 32'(bus.status), 32'd1);
`endif
    step(4'b0000, 2'd0);
    step(4'b0000, 2'd0);

    // Random traffic against the model.
    rr = 4'h0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rr = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 9))
        0, 1, 2: ll = 2'd0;
        3, 4, 5, 6: ll = 2'd1;
        7, 8: ll = 2'd2;
        default: ll = 2'd3;
      endcase
      step(rr, ll);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
